// File: rtl/redmule_job_dispatcher.sv
// Drives RedMulE's periph slave port: ACQUIRE (retry and backoff on busy), program job registers, TRIGGER, await evt_done_i, report.
// ACQUIRE goes out the cycle after accept. A request is held until gnt, and the completion record is held until done_ready_i.
module redmule_job_dispatcher #(
    parameter int unsigned N_JOB_REGS     = 12,
    parameter int unsigned ID_WIDTH       = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [31:0] REG_OFFS       = 32'h40,
    parameter int unsigned BACKOFF_CYCLES = 16,
    parameter int unsigned MAX_RETRIES    = 255,
    parameter int unsigned CORE_ID        = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [N_JOB_REGS*32-1:0]   job_regs_i,
    output logic                       periph_req_o,
    input  logic                       periph_gnt_i,
    output logic [31:0]                periph_add_o,
    output logic                       periph_wen_o,
    output logic [3:0]                 periph_be_o,
    output logic [31:0]                periph_data_o,
    output logic [ID_WIDTH-1:0]        periph_id_o,
    input  logic                       periph_r_valid_i,
    input  logic [31:0]                periph_r_data_i,
    input  logic [ID_WIDTH-1:0]        periph_r_id_i,
    input  logic                       evt_done_i,
    output logic                       done_valid_o,
    input  logic                       done_ready_i,
    output logic [7:0]                 done_job_id_o,
    output logic                       done_err_o,
    output logic                       busy_o
);

    localparam int IDX_W = (N_JOB_REGS > 1) ? $clog2(N_JOB_REGS) : 1;
    localparam int BW    = $clog2(BACKOFF_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, ACQ_REQ, ACQ_WAIT, BACKOFF, WRITE, TRIG, WAIT_DONE, REPORT
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         retry_q, retry_d;
    logic [BW-1:0]      boff_q, boff_d;
    logic [7:0]         job_id_q, job_id_d;
    logic               err_q, err_d;
    logic               load_buf;
    logic [31:0]        buf_q [N_JOB_REGS];
    logic               unused_rdata;

    assign unused_rdata = ^periph_r_data_i[30:8];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        boff_d   = boff_q;
        job_id_d = job_id_q;
        err_d    = err_q;
        load_buf = 1'b0;
        unique case (state_q)
            IDLE: if (job_valid_i) begin
                load_buf = 1'b1;
                retry_d  = '0;
                job_id_d = '0;
                err_d    = 1'b0;
                state_d  = ACQ_REQ;
            end
            ACQ_REQ: if (periph_gnt_i) state_d = ACQ_WAIT;
            // Only responses carrying our own ID answer the ACQUIRE.
            ACQ_WAIT: if (periph_r_valid_i && periph_r_id_i == ID_WIDTH'(CORE_ID)) begin
                if (periph_r_data_i[31]) begin
                    if (retry_q == 8'(MAX_RETRIES)) begin
                        err_d   = 1'b1;
                        state_d = REPORT;
                    end else begin
                        retry_d = retry_q + 8'd1;
                        boff_d  = '0;
                        state_d = BACKOFF;
                    end
                end else begin
                    job_id_d = periph_r_data_i[7:0];
                    idx_d    = '0;
                    state_d  = WRITE;
                end
            end
            BACKOFF: begin
                if (boff_q == BW'(BACKOFF_CYCLES - 1)) state_d = ACQ_REQ;
                else                                   boff_d  = boff_q + BW'(1);
            end
            WRITE: if (periph_gnt_i) begin
                if (idx_q == IDX_W'(N_JOB_REGS - 1)) state_d = TRIG;
                else                                  idx_d   = idx_q + IDX_W'(1);
            end
            TRIG:      if (periph_gnt_i) state_d = WAIT_DONE;
            WAIT_DONE: if (evt_done_i)   state_d = REPORT;
            REPORT:    if (done_ready_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            retry_q  <= '0;
            boff_q   <= '0;
            job_id_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            boff_q   <= boff_d;
            job_id_q <= job_id_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_buf) begin
            for (int i = 0; i < int'(N_JOB_REGS); i++) buf_q[i] <= job_regs_i[i*32 +: 32];
        end
    end

    // Port fields are decoded from state and registers only, so they are stable while stalled.
    always_comb begin
        periph_req_o  = 1'b0;
        periph_add_o  = 32'h0;
        periph_wen_o  = 1'b1;
        periph_data_o = 32'h0;
        unique case (state_q)
            ACQ_REQ: begin
                periph_req_o = 1'b1;
                periph_add_o = BASE_ADDR + 32'h4;
            end
            WRITE: begin
                periph_req_o  = 1'b1;
                periph_wen_o  = 1'b0;
                periph_add_o  = BASE_ADDR + REG_OFFS + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
                periph_data_o = buf_q[idx_q];
            end
            TRIG: begin
                periph_req_o = 1'b1;
                periph_wen_o = 1'b0;
                periph_add_o = BASE_ADDR;
            end
            default: ;
        endcase
    end

    assign periph_be_o   = 4'hF;
    assign periph_id_o   = ID_WIDTH'(CORE_ID);
    assign job_ready_o   = (state_q == IDLE);
    assign busy_o        = (state_q != IDLE);
    assign done_valid_o  = (state_q == REPORT);
    assign done_job_id_o = job_id_q;
    assign done_err_o    = err_q;

endmodule

// File: tb/tb_redmule_job_dispatcher.sv
// Scoreboard bench: directed jobs push expected periph transactions and completion records; a monitor checks them at negedge.
module tb_redmule_job_dispatcher;

    localparam int CORE_ID = 0;
    localparam int NREG    = 12;

    logic               clk_i = 1'b0;
    logic               rst_i, clear_i, job_valid_i, job_ready_o;
    logic [NREG*32-1:0] job_regs_i;
    logic               periph_req_o, periph_gnt_i, periph_wen_o;
    logic [31:0]        periph_add_o, periph_data_o, periph_r_data_i;
    logic [3:0]         periph_be_o;
    logic [7:0]         periph_id_o, periph_r_id_i, done_job_id_o;
    logic               periph_r_valid_i, evt_done_i, done_valid_o, done_ready_i, done_err_o, busy_o;

    redmule_job_dispatcher #(.N_JOB_REGS(NREG), .ID_WIDTH(8), .BASE_ADDR(32'h0), .REG_OFFS(32'h40),
                             .BACKOFF_CYCLES(16), .MAX_RETRIES(2), .CORE_ID(CORE_ID)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_regs_i(job_regs_i),
        .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_add_o(periph_add_o),
        .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
        .periph_id_o(periph_id_o), .periph_r_valid_i(periph_r_valid_i), .periph_r_data_i(periph_r_data_i),
        .periph_r_id_i(periph_r_id_i), .evt_done_i(evt_done_i), .done_valid_o(done_valid_o),
        .done_ready_i(done_ready_i), .done_job_id_o(done_job_id_o), .done_err_o(done_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; logic wen; logic [31:0] data; int cyc; } txn_t;
    typedef struct { int id; logic err; int cyc; } rec_t;

    txn_t        exp_txn[$];
    rec_t        exp_done[$];
    logic [31:0] acq_q[$];
    int n_chk = 0, n_pass = 0;
    int cyc = 0, acc_cyc = 0, evt_cyc = -100, rise_cyc = 0;
    bit stall_mode = 0, gnt_block = 0, spur_evt = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] word(input int seed, input int i);
        return 32'hD000_0000 | (32'(seed) << 8) | 32'(i);
    endfunction

    task automatic push_acq(input int rel);
        exp_txn.push_back('{32'h4, 1'b1, 32'h0, rel});
    endtask
    task automatic push_writes(input int seed, input int n, input int start);
        for (int i = 0; i < n; i++)
            exp_txn.push_back('{32'h40 + 32'(4*i), 1'b0, word(seed, i), (start < 0) ? -1 : start + i});
    endtask
    task automatic push_trig(input int rel);
        exp_txn.push_back('{32'h0, 1'b0, 32'h0, rel});
    endtask

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    task automatic accept_job(input int seed);
        int n = 0;
        while (!job_ready_o && n < 100) begin step(); n++; end
        check("job_ready_before_accept", job_ready_o, 1);
        for (int i = 0; i < NREG; i++) job_regs_i[i*32 +: 32] = word(seed, i);
        job_valid_i = 1'b1;
        acc_cyc     = cyc;
        step();
        job_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_txn.size() != 0 || exp_done.size() != 0 || busy_o) && n < budget) begin step(); n++; end
        check(name, exp_txn.size() + exp_done.size() + int'(busy_o), 0);
        exp_txn.delete();
        exp_done.delete();
    endtask

    // Accelerator-side responder; drives 1 time unit after the driver so driver flags apply the same cycle.
    initial begin
        int          pend_dly = 0, evt_cnt = 0, stall_left = 0;
        logic [31:0] pend_data = 0;
        periph_gnt_i = 0; periph_r_valid_i = 0; periph_r_data_i = 0; periph_r_id_i = 8'(CORE_ID); evt_done_i = 0;
        forever begin
            @(posedge clk_i); #2;
            periph_r_valid_i = 1'b0;
            periph_r_id_i    = 8'(CORE_ID);
            evt_done_i       = spur_evt;
            if (pend_dly > 0) begin
                pend_dly--;
                if (pend_dly == 0) begin
                    periph_r_valid_i = 1'b1; periph_r_data_i = pend_data;
                end else if (pend_dly == 2) begin
                    periph_r_valid_i = 1'b1; periph_r_data_i = 32'h55; periph_r_id_i = 8'(CORE_ID + 1);
                end
            end
            if (evt_cnt > 0) begin
                evt_cnt--;
                if (evt_cnt == 0) evt_done_i = 1'b1;
            end
            if (gnt_block)            periph_gnt_i = 1'b0;
            else if (!stall_mode)     periph_gnt_i = 1'b1;
            else if (stall_left == 0) periph_gnt_i = 1'b1;
            else begin periph_gnt_i = 1'b0; stall_left--; end
            @(negedge clk_i);
            if (periph_req_o && periph_gnt_i) begin
                if (stall_mode) stall_left = $urandom_range(0, 5);
                if (periph_wen_o) begin
                    pend_dly  = stall_mode ? 3 : 1;
                    pend_data = (acq_q.size() != 0) ? acq_q.pop_front() : 32'h8000_0000;
                end else if (periph_add_o == 32'h0) begin
                    evt_cnt = 4;
                end
            end
        end
    end

    // Monitor: scoreboard pops, stall stability and post-report readiness.
    initial begin
        bit          prev_stall = 0, prev_dv = 0, prev_hs = 0;
        logic [64:0] prev_fields = '0;
        txn_t        t;
        rec_t        d;
        forever begin
            @(negedge clk_i);
            if (evt_done_i) evt_cyc = cyc;
            if (done_valid_o && !prev_dv) rise_cyc = cyc;
            prev_dv = done_valid_o;
            if (prev_hs) check("ready_after_report", job_ready_o, 1);
            prev_hs = done_valid_o && done_ready_i;
            if (prev_stall)
                check("stall_stable", {periph_req_o, periph_add_o, periph_wen_o, periph_data_o}, {1'b1, prev_fields[64:0]});
            prev_stall  = periph_req_o && !periph_gnt_i && !clear_i && !rst_i;
            prev_fields = {periph_add_o, periph_wen_o, periph_data_o};
            if (periph_req_o && periph_gnt_i) begin
                if (exp_txn.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_txn: got add=0x%0h wen=%0d, expected none", periph_add_o, periph_wen_o);
                end else begin
                    t = exp_txn.pop_front();
                    check("txn_addr", periph_add_o, t.addr);
                    check("txn_wen_be", {periph_wen_o, periph_be_o}, {t.wen, 4'hF});
                    if (!t.wen) check("txn_data", periph_data_o, t.data);
                    if (t.cyc >= 0) check("txn_cycle", cyc - acc_cyc, t.cyc);
                end
            end
            if (done_valid_o && done_ready_i) begin
                if (exp_done.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_record: got id=0x%0h err=%0d, expected none", done_job_id_o, done_err_o);
                end else begin
                    d = exp_done.pop_front();
                    check("rec_err", done_err_o, d.err);
                    if (d.id >= 0) check("rec_id", done_job_id_o, d.id);
                    if (d.cyc >= 0) check("rec_cycle", rise_cyc - acc_cyc, d.cyc);
                    else            check("rec_after_evt", rise_cyc - evt_cyc, 1);
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk_i);
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1; clear_i = 0; job_valid_i = 0; job_regs_i = '0; done_ready_i = 1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        check("rst_ready_busy", {job_ready_o, busy_o, done_valid_o, done_err_o}, 4'b1000);
        check("rst_periph", {periph_req_o, periph_wen_o, periph_be_o, periph_id_o}, {1'b0, 1'b1, 4'hF, 8'(CORE_ID)});
        check("rst_add_data", {periph_add_o, periph_data_o}, 64'h0);
        check("rst_job_id", done_job_id_o, 0);

        // Ideal port: reference latency, ACQUIRE returns context 1.
        acq_q.push_back(32'h1);
        push_acq(1); push_writes(1, NREG, 3); push_trig(15); exp_done.push_back('{1, 1'b0, -1});
        accept_job(1);
        wait_idle("drain_basic", 200);

        // Two busy ACQUIREs then success: requests 18 cycles apart.
        acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'hFFFF_FFFF); acq_q.push_back(32'h0);
        push_acq(1); push_acq(19); push_acq(37); push_writes(2, NREG, 39); push_trig(51);
        exp_done.push_back('{0, 1'b0, -1});
        accept_job(2);
        wait_idle("drain_retry", 300);

        // Always busy with MAX_RETRIES=2: three reads then error record, no writes.
        repeat (3) acq_q.push_back(32'hFFFF_FFFF);
        push_acq(1); push_acq(19); push_acq(37); exp_done.push_back('{-1, 1'b1, 39});
        accept_job(3);
        wait_idle("drain_abort", 300);

        // Random grant stalls plus a wrong-ID response during ACQ_WAIT.
        stall_mode = 1;
        acq_q.push_back(32'h3);
        push_acq(-1); push_writes(4, NREG, -1); push_trig(-1); exp_done.push_back('{3, 1'b0, -1});
        accept_job(4);
        wait_idle("drain_stall", 1000);
        stall_mode = 0;

        // Clear while idx 5 is being presented, then a clean job.
        acq_q.push_back(32'h7);
        push_acq(1); push_writes(5, 5, 3);
        accept_job(5);
        while (cyc < acc_cyc + 8) step();
        check("clr_at_idx5", {periph_req_o, periph_add_o}, {1'b1, 32'h54});
        clear_i = 1; gnt_block = 1;
        step();
        check("clr_next_cycle", {periph_req_o, busy_o, job_ready_o}, 3'b001);
        check("clr_writes_done", exp_txn.size(), 0);
        clear_i = 0; gnt_block = 0;
        acq_q.push_back(32'h8);
        push_acq(1); push_writes(6, NREG, 3); push_trig(15); exp_done.push_back('{8, 1'b0, -1});
        accept_job(6);
        wait_idle("drain_after_clear", 200);

        // Completion record backpressure.
        done_ready_i = 0;
        acq_q.push_back(32'h9);
        push_acq(1); push_writes(7, NREG, 3); push_trig(15); exp_done.push_back('{9, 1'b0, -1});
        accept_job(7);
        n = 0;
        while (!done_valid_o && n < 100) begin step(); n++; end
        for (int i = 0; i < 10; i++) begin
            check("rec_hold", {done_valid_o, done_job_id_o, done_err_o, job_ready_o}, {1'b1, 8'h9, 1'b0, 1'b0});
            step();
        end
        done_ready_i = 1;
        wait_idle("drain_backpressure", 50);

        // Spurious completion event while idle.
        spur_evt = 1;
        step();
        spur_evt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("spurious_evt_idle", {done_valid_o, busy_o}, 2'b00);
        end

        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/redmule_job_dispatcher.md
# redmule_job_dispatcher

Initiator-side job sequencer for the RedMulE configuration port. It accepts a complete job descriptor from a local producer (a core-side queue or DMA-fed descriptor FIFO) and acquires an accelerator context by reading ACQUIRE, retrying on busy. It then programs the job registers, writes TRIGGER, waits for the accelerator's completion event and returns a completion record. It drives the master side of the HWPE peripheral protocol that the accelerator controller serves as a slave.

## Interface
- N_JOB_REGS, 12: job-register words written per job.
- ID_WIDTH, 8: periph transaction ID width.
- BASE_ADDR, 32'h0: accelerator register base.
- REG_OFFS, 32'h40: byte offset of job register 0; register i is at BASE_ADDR+REG_OFFS+4*i.
- BACKOFF_CYCLES, 16: idle cycles between ACQUIRE retries (≥1).
- MAX_RETRIES, 255: busy ACQUIRE responses tolerated before the job is aborted with error.
- CORE_ID, 0: constant driven on periph_id_o.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as rst_i.
- job_valid_i  in  1  descriptor valid.
- job_ready_o  out  1  descriptor accepted when job_valid_i and job_ready_o are both high.
- job_regs_i  in  N_JOB_REGS×32  descriptor words.
- periph_req_o  out  1  request.
- periph_gnt_i  in  1  grant.
- periph_add_o  out  32  byte address.
- periph_wen_o  out  1  1 = read, 0 = write.
- periph_be_o  out  4  byte enables, always 4'hF.
- periph_data_o  out  32  write data.
- periph_id_o  out  ID_WIDTH  transaction ID.
- periph_r_valid_i  in  1  read response valid.
- periph_r_data_i  in  32  read data.
- periph_r_id_i  in  ID_WIDTH  response ID.
- evt_done_i  in  1  one-cycle completion event from the accelerator for this core.
- done_valid_o  out  1  completion record valid.
- done_ready_i  in  1  completion record consumed.
- done_job_id_o  out  8  context ID returned by ACQUIRE.
- done_err_o  out  1  job aborted because retries were exhausted.
- busy_o  out  1  high in every state except IDLE.

## Operation
- Register map: TRIGGER at 0x00, ACQUIRE at 0x04. Job register i is at REG_OFFS+4*i. All addresses are relative to BASE_ADDR.
- FSM states and transitions:
  - IDLE: job_ready_o=1. On accept, latch job_regs_i into the internal buffer, clear the retry counter, go to ACQ_REQ.
  - ACQ_REQ: read ACQUIRE (req=1, wen=1). On gnt go to ACQ_WAIT.
  - ACQ_WAIT: wait for r_valid with r_id==CORE_ID. Responses with a mismatching ID are ignored.
    - r_data[31]=1 (no free context): if retries==MAX_RETRIES go to REPORT with err=1; otherwise increment retries and go to BACKOFF.
    - r_data[31]=0: latch r_data[7:0] as job_id and go to WRITE.
  - BACKOFF: count BACKOFF_CYCLES cycles, then go to ACQ_REQ.
  - WRITE: write buffer word idx to REG_OFFS+4*idx, with idx 0..N_JOB_REGS-1 in order. idx advances on gnt. After the last gnt go to TRIG.
  - TRIG: write 32'h0 to TRIGGER. On gnt go to WAIT_DONE.
  - WAIT_DONE: on evt_done_i go to REPORT with err=0.
  - REPORT: done_valid_o=1. On done_ready_i go to IDLE.
- At most one periph transaction is outstanding. Write responses are not awaited: a write completes at gnt. r_valid outside ACQ_WAIT is ignored.
- While req is high and gnt is low, add, wen, data and id hold stable and req stays high. No request is withdrawn.
- evt_done_i outside WAIT_DONE is ignored.
- The retry counter is 8 bits wide. MAX_RETRIES=255 permits 256 ACQUIRE attempts.
- rst_i or clear_i in any state returns the FSM to IDLE and drops any in-flight request immediately. The descriptor is lost and no completion record is produced.

## Timing
- Reset values: job_ready_o=1 (IDLE); periph_req_o=0; periph_add_o=0; periph_wen_o=1; periph_data_o=0; periph_be_o=4'hF; periph_id_o=CORE_ID; done_valid_o=0; done_job_id_o=0; done_err_o=0; busy_o=0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to periph_req_o.
- Reference latency, with gnt tied high, r_valid one cycle after gnt, and the accept at cycle 0:
  - ACQUIRE request in cycle 1.
  - r_valid in cycle 2.
  - Writes in cycles 3..2+N_JOB_REGS.
  - TRIGGER in cycle 3+N_JOB_REGS.
  - WAIT_DONE from cycle 4+N_JOB_REGS.
  - done_valid_o rises the cycle after evt_done_i.
- Back-to-back: job_ready_o rises the cycle after the REPORT handshake.
- One busy ACQUIRE adds exactly 1 (gnt) + 1 (r_valid) + BACKOFF_CYCLES cycles.

## Test plan
- N_JOB_REGS=12, gnt and r_valid ideal, ACQUIRE returns 0x00000001 -> exactly 12 writes at 0x40..0x6C with data equal to the descriptor, TRIGGER write in cycle 15, done_job_id_o=1 and err=0 one cycle after the evt pulse.
- ACQUIRE returns 0xFFFFFFFF twice, then 0x00000000, with BACKOFF_CYCLES=16 -> three ACQUIRE reads whose requests are spaced 18 cycles apart, then normal programming with job_id=0.
- MAX_RETRIES=2 and ACQUIRE always busy -> three reads, then done_valid_o with done_err_o=1, no writes and no TRIGGER.
- Random gnt stalls of 0-5 cycles -> add, data and wen stable while stalled, every write issued exactly once in order, and a stray r_valid with wrong ID in ACQ_WAIT is ignored.
- clear_i asserted mid-WRITE (idx=5) -> periph_req_o=0 next cycle, IDLE with busy_o=0; the next job programs all 12 registers from idx 0.
- done_ready_i held low for 10 cycles -> done_valid_o held with stable fields and job_ready_o=0; a spurious evt_done_i during IDLE produces no record.
